// File: rtl/clock_reset_sequencer.sv
// Soft-reset sequencer: holds selected domain resets, then releases them in
// ascending index order with a fixed gap between releases.
module clock_reset_sequencer #(
  parameter int unsigned HOLD_CYCLES = 16,
  parameter int unsigned GAP_CYCLES  = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       io_req_valid,
  output logic       io_req_ready,
  input  logic [2:0] io_req_mask,
  output logic       io_out_0_reset,
  output logic       io_out_1_reset,
  output logic       io_out_2_reset,
  output logic       io_busy,
  output logic       io_done
);

  localparam int unsigned MaxCycles = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);

  localparam logic [CntW-1:0] HoldLast = CntW'(HOLD_CYCLES - 1);
  localparam logic [CntW-1:0] GapLast  = CntW'(GAP_CYCLES - 1);

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StHold    = 2'd1;
  localparam logic [1:0] StRelease = 2'd2;

  logic [1:0]      r_state, w_state_d;
  logic [2:0]      r_mask, w_mask_d;
  logic [CntW-1:0] r_cnt, w_cnt_d;
  logic [2:0]      r_out, w_out_d;
  logic            r_busy, w_busy_d;
  logic            r_ready, w_ready_d;
  logic            r_done, w_done_d;

  logic [2:0] w_low;
  logic [2:0] w_rest;
  logic       w_accept;
  logic       w_release;

  // r_mask holds the domains still waiting for release; w_low is the next one.
  assign w_low    = r_mask & (~r_mask + 3'd1);
  assign w_rest   = r_mask & ~w_low;
  assign w_accept = io_req_valid & r_ready;

  always_comb begin
    w_state_d = r_state;
    w_mask_d  = r_mask;
    w_cnt_d   = r_cnt;
    w_out_d   = r_out;
    w_busy_d  = r_busy;
    w_ready_d = r_ready;
    w_done_d  = 1'b0;
    w_release = 1'b0;

    case (r_state)
      StIdle: begin
        if (w_accept) begin
          w_mask_d = io_req_mask;
          if (io_req_mask != 3'b000) begin
            w_state_d = StHold;
            w_cnt_d   = '0;
            w_out_d   = r_out | io_req_mask;
            w_busy_d  = 1'b1;
            w_ready_d = 1'b0;
          end else begin
            w_done_d = 1'b1;
          end
        end
      end
      StHold: begin
        if (r_cnt == HoldLast) w_release = 1'b1;
        else                   w_cnt_d   = r_cnt + CntW'(1);
      end
      StRelease: begin
        if (r_cnt == GapLast) w_release = 1'b1;
        else                  w_cnt_d   = r_cnt + CntW'(1);
      end
      default: begin
        w_state_d = StIdle;
        w_busy_d  = 1'b0;
        w_ready_d = 1'b1;
      end
    endcase

    if (w_release) begin
      w_out_d  = r_out & ~w_low;
      w_mask_d = w_rest;
      w_cnt_d  = '0;
      if (w_rest == 3'b000) begin
        w_state_d = StIdle;
        w_busy_d  = 1'b0;
        w_ready_d = 1'b1;
        w_done_d  = 1'b1;
      end else begin
        w_state_d = StRelease;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= StHold;
      r_mask  <= 3'b111;
      r_cnt   <= '0;
      r_out   <= 3'b111;
      r_busy  <= 1'b1;
      r_ready <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_mask  <= w_mask_d;
      r_cnt   <= w_cnt_d;
      r_out   <= w_out_d;
      r_busy  <= w_busy_d;
      r_ready <= w_ready_d;
      r_done  <= w_done_d;
    end
  end

  assign io_out_0_reset = r_out[0];
  assign io_out_1_reset = r_out[1];
  assign io_out_2_reset = r_out[2];
  assign io_busy        = r_busy;
  assign io_req_ready   = r_ready;
  assign io_done        = r_done;

endmodule

// File: tb/tb_clock_reset_sequencer.sv
// Scoreboard bench: stimulus queues expected output-vector changes stamped with
// the edge number; the monitor pops one entry per observed change.
module tb_clock_reset_sequencer;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       io_req_valid = 1'b0;
  logic [2:0] io_req_mask = 3'b000;
  logic       io_req_ready;
  logic       io_out_0_reset, io_out_1_reset, io_out_2_reset;
  logic       io_busy, io_done;

  clock_reset_sequencer #(
    .HOLD_CYCLES(16),
    .GAP_CYCLES (4)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .io_req_valid  (io_req_valid),
    .io_req_ready  (io_req_ready),
    .io_req_mask   (io_req_mask),
    .io_out_0_reset(io_out_0_reset),
    .io_out_1_reset(io_out_1_reset),
    .io_out_2_reset(io_out_2_reset),
    .io_busy       (io_busy),
    .io_done       (io_done)
  );

  initial forever #5 clock = ~clock;

  // {out2, out1, out0, busy, ready, done}
  logic [5:0] vec;
  assign vec = {io_out_2_reset, io_out_1_reset, io_out_0_reset, io_busy, io_req_ready, io_done};

  int         cyc = 0;
  int         errors = 0;
  int         checks = 0;
  int         q_at[$];
  logic [5:0] q_vec[$];
  string      q_name[$];

  logic [5:0] prev = 6'b111100;
  int         m_at;
  logic [5:0] m_vec;
  string      m_name;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (vec !== prev) begin
      checks++;
      if (q_at.size() == 0) begin
        errors++;
        $display("FAIL unexpected_change: got=%b at cyc %0d, required no change from %b",
                 vec, cyc, prev);
      end else begin
        m_at   = q_at.pop_front();
        m_vec  = q_vec.pop_front();
        m_name = q_name.pop_front();
        if (m_at != cyc || m_vec !== vec) begin
          errors++;
          $display("FAIL %s: got=%b at cyc %0d, required=%b at cyc %0d",
                   m_name, vec, cyc, m_vec, m_at);
        end
      end
      prev = vec;
    end
  end

  task automatic expect_ev(input int at, input logic [5:0] v, input string name);
    q_at.push_back(at);
    q_vec.push_back(v);
    q_name.push_back(name);
  endtask

  task automatic check_now(input string name, input logic [5:0] exp);
    checks++;
    if (vec !== exp) begin
      errors++;
      $display("FAIL %s: got=%b required=%b", name, vec, exp);
    end
  endtask

  task automatic edges(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  int base;
  int t;

  initial begin
    #1 reset = 1'b1;
    #1 check_now("reset_async_state", 6'b111100);
    edges(3);

    // Power-on with a mask 010 request held throughout
    reset = 1'b0;
    io_req_valid = 1'b1;
    io_req_mask  = 3'b010;
    base = cyc;
    expect_ev(base + 16, 6'b110100, "por_out0_release");
    expect_ev(base + 20, 6'b100100, "por_out1_release");
    expect_ev(base + 24, 6'b000011, "por_done");
    expect_ev(base + 25, 6'b010100, "held_req_accept");
    expect_ev(base + 41, 6'b000011, "held_req_done");
    expect_ev(base + 42, 6'b000010, "held_req_idle");
    edges(25);
    io_req_valid = 1'b0;
    io_req_mask  = 3'b000;
    edges(18);

    // Mask 101, with an ignored request while busy
    t = cyc + 1;
    expect_ev(t,      6'b101100, "m101_assert");
    expect_ev(t + 16, 6'b100100, "m101_out0_release");
    expect_ev(t + 20, 6'b000011, "m101_done");
    expect_ev(t + 21, 6'b000010, "m101_idle");
    io_req_valid = 1'b1;
    io_req_mask  = 3'b101;
    edges(1);
    io_req_valid = 1'b0;
    edges(4);
    io_req_valid = 1'b1;
    io_req_mask  = 3'b010;
    edges(1);
    io_req_valid = 1'b0;
    edges(18);

    // Mask 100: skipped domains add no gap
    t = cyc + 1;
    expect_ev(t,      6'b100100, "m100_assert");
    expect_ev(t + 16, 6'b000011, "m100_done");
    expect_ev(t + 17, 6'b000010, "m100_idle");
    io_req_valid = 1'b1;
    io_req_mask  = 3'b100;
    edges(1);
    io_req_valid = 1'b0;
    edges(18);

    // Mask 000: immediate done, never busy
    t = cyc + 1;
    expect_ev(t,     6'b000011, "m000_done");
    expect_ev(t + 1, 6'b000010, "m000_idle");
    io_req_valid = 1'b1;
    io_req_mask  = 3'b000;
    edges(1);
    check_now("m000_not_busy", 6'b000011);
    io_req_valid = 1'b0;
    edges(3);

    // Reset from idle, then reset again mid power-on sequence
    expect_ev(cyc, 6'b111100, "reset_from_idle");
    reset = 1'b1;
    #1 check_now("reset_async_idle", 6'b111100);
    edges(2);
    reset = 1'b0;
    base = cyc;
    expect_ev(base + 16, 6'b110100, "por2_out0_release");
    expect_ev(base + 18, 6'b111100, "reset_mid_sequence");
    edges(18);
    reset = 1'b1;
    #1 check_now("reset_async_mid", 6'b111100);
    edges(2);
    reset = 1'b0;
    base = cyc;
    expect_ev(base + 16, 6'b110100, "por3_out0_release");
    expect_ev(base + 20, 6'b100100, "por3_out1_release");
    expect_ev(base + 24, 6'b000011, "por3_done");
    expect_ev(base + 25, 6'b000010, "por3_idle");
    edges(28);

    checks++;
    if (q_at.size() != 0) begin
      errors++;
      $display("FAIL missing_events: got=%0d pending events, required=0 (next %s)",
               q_at.size(), q_name[0]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/clock_reset_sequencer.md
CLOCK_RESET_SEQUENCER -- requirements
Module: clock_reset_sequencer

Interface
REQ-001 The block SHALL have parameter HOLD_CYCLES, default 16, meaning the number of cycles the selected domain resets stay asserted before the first release (legal range >= 1).
REQ-002 The block SHALL have parameter GAP_CYCLES, default 4, meaning the number of cycles between releases of consecutive selected domains (legal range >= 1).
REQ-003 Port: clock  input  1  the single clock; all sequential state is clocked on its rising edge.
REQ-004 Port: reset  input  1  reset, asynchronous, active-high.
REQ-005 Port: io_req_valid  input  1  a soft-reset request is present.
REQ-006 Port: io_req_ready  output  1  the block can accept a request.
REQ-007 Port: io_req_mask  input  3  domains to reset; bit n selects domain n.
REQ-008 Port: io_out_0_reset / io_out_1_reset / io_out_2_reset  output  1 each  active-high reset to broadcast domains 0, 1 and 2.
REQ-009 Port: io_busy  output  1  a sequence is in progress.
REQ-010 Port: io_done  output  1  one-cycle pulse marking the end of a sequence.

Function
REQ-011 The FSM SHALL have three states: HOLD, RELEASE and IDLE.
REQ-012 All outputs SHALL be driven from registers, so the io_out_n_reset outputs are glitch-free.
REQ-013 The cycle counter width SHALL be clog2(max(HOLD_CYCLES, GAP_CYCLES)+1); the counter SHALL never wrap.
REQ-014 IDLE state:
- io_req_ready=1, io_busy=0.
- A request is accepted on a rising edge where io_req_valid && io_req_ready; the mask is latched on that edge.
REQ-015 Accepting a nonzero mask SHALL have this effect after the accepting edge:
- the selected io_out_n_reset outputs are 1;
- unselected outputs keep their current value;
- the state is HOLD and the counter is 0.
REQ-016 Accepting mask 3'b000 SHALL leave the state in IDLE, assert no reset, and pulse io_done in the following cycle.
REQ-017 HOLD state:
- io_busy=1, io_req_ready=0.
- The state SHALL last exactly HOLD_CYCLES cycles.
- The first selected domain (lowest index) is released on the HOLD_CYCLES-th edge after entry, and the state moves to RELEASE.
REQ-018 RELEASE state:
- Selected domains SHALL be released one at a time in ascending index order.
- Each release SHALL occur exactly GAP_CYCLES edges after the previous release.
- Unselected domains SHALL be skipped and add no gap.
REQ-019 The edge that releases the last selected domain SHALL also:
- move the state to IDLE;
- set io_done=1 for exactly that following cycle, in which io_req_ready=1 and io_busy=0.
REQ-020 While io_busy=1, io_req_valid SHALL be ignored and io_req_mask SHALL have no effect; a held request is accepted on the first IDLE cycle, including the io_done cycle.
REQ-021 A released domain SHALL stay deasserted until it is selected by a later request or reset is asserted.

Reset
REQ-022 While reset=1, the block SHALL immediately hold the following, without waiting for a clock edge:
- io_out_0_reset = io_out_1_reset = io_out_2_reset = 1;
- io_busy=1, io_req_ready=0, io_done=0;
- state HOLD, latched mask 3'b111, counter 0.
REQ-023 After reset deasserts, the block SHALL run the HOLD/RELEASE sequence of REQ-017 to REQ-019 with mask 3'b111, counting edges from the first rising edge after deassertion.
REQ-024 Reset asserted mid-sequence SHALL do the following:
- abort the sequence with no io_done pulse;
- reassert all three domain resets immediately;
- restart the power-on sequence after deassertion.

Verification (HOLD_CYCLES=16, GAP_CYCLES=4)
REQ-025 Power-on: deassert reset, counting edges from 1 -> out_0 falls after edge 16, out_1 after edge 20, out_2 after edge 24; io_done=1 only in the cycle after edge 24; io_req_ready=1 from then on.
REQ-026 Request mask 3'b101 accepted at edge T while IDLE -> out_0 and out_2 =1 after T; out_0 falls after T+16; out_2 falls after T+20; out_1 stays 0 throughout; a single io_done pulse.
REQ-027 Request mask 3'b100 accepted at edge T -> only out_2 =1; it falls after T+16 with no gap inserted for the skipped domains 0 and 1; io_done follows.
REQ-028 Request mask 3'b000 -> no output reset changes; io_done pulses in the next cycle; io_busy stays 0.
REQ-029 io_req_valid held high with mask 3'b010 during the power-on sequence -> io_req_ready=0 until the io_done cycle; the request is accepted on the edge ending that cycle; out_1 rises and falls 16 edges later.
REQ-030 Reset asserted asynchronously two cycles after out_0 is released -> all three resets go to 1 before the next clock edge; no io_done pulse; after deassertion the REQ-025 timing repeats exactly.
